mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder for the multi-cycle control unit
//
// Accepts a level-signalled read/write request and holds it for WAIT_CYCLES
// wait states. It then performs the access on an internal word array and
// returns a one-cycle mem_ready pulse. Read data is registered on the edge
// that enters the response state.
//
// Ports:
//   CLK        rising-edge clock
//   Reset      asynchronous active-low reset
//   mem_read   read request level
//   mem_write  write request level
//   mem_addr   word address, captured on accept
//   mem_wdata  write data, captured on accept
//   mem_rdata  read data, valid with mem_ready on a read, held otherwise
//   mem_ready  one-cycle completion pulse
//   mem_busy   high while in WAIT or RESP
//   mem_err    one-cycle pulse with mem_ready on a bad access
//   rd_count   (MEM_STATS_EN only) saturating count of good reads
//   wr_count   (MEM_STATS_EN only) saturating count of good writes
//
// Optional feature macro: MEM_STATS_EN
module mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              oob;
  logic              bad;
  logic [IDX_W-1:0]  idx;

  // Word array; intentionally not reset so contents survive Reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Full-width compare: addresses at or above DEPTH never alias onto the array.
  assign oob = ({1'b0, addr_q} >= DEPTH_L);
  assign bad = (rd_q & wr_q) | oob;
  assign idx = addr_q[IDX_W-1:0];

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
`ifdef MEM_STATS_EN
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_read | mem_write) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          rd_d    = mem_read;
          wr_d    = mem_write;
          cnt_d   = WAIT_L;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // The access itself happens on the edge that enters RESP, so a
          // reset during WAIT leaves the array untouched.
          state_d = ST_RESP;
          ready_d = 1'b1;
          err_d   = bad;
          if (rd_q) begin
            rdata_d = bad ? '0 : mem_q[idx];
          end
          if (wr_q && !bad) begin
            mem_we = 1'b1;
          end
`ifdef MEM_STATS_EN
          if (!bad && rd_q && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
          if (!bad && wr_q && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_STATS_EN
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef MEM_STATS_EN
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_busy  = busy_q;
  assign mem_err   = err_q;
`ifdef MEM_STATS_EN
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        sel;          // 0: one-wait-state instance, 1: zero-wait-state instance
  logic        rq_rd, rq_wr;
  logic [15:0] rq_addr, rq_wdata;

  logic        rd1, wr1, rd0, wr0;
  logic [15:0] rdata1, rdata0;
  logic        ready1, ready0, busy1, busy0, err1, err0;
  logic [15:0] rdata;
  logic        ready, busy, err;
`ifdef MEM_STATS_EN
  logic [15:0] rdc1, wrc1, rdc0, wrc0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  assign rd1 = sel ? 1'b0 : rq_rd;
  assign wr1 = sel ? 1'b0 : rq_wr;
  assign rd0 = sel ? rq_rd : 1'b0;
  assign wr0 = sel ? rq_wr : 1'b0;
  assign rdata = sel ? rdata0 : rdata1;
  assign ready = sel ? ready0 : ready1;
  assign busy  = sel ? busy0  : busy1;
  assign err   = sel ? err0   : err1;

  mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(1)) dut1 (
    .CLK(CLK), .Reset(Reset), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(rq_addr), .mem_wdata(rq_wdata), .mem_rdata(rdata1),
    .mem_ready(ready1), .mem_busy(busy1), .mem_err(err1)
`ifdef MEM_STATS_EN
    , .rd_count(rdc1), .wr_count(wrc1)
`endif
  );

  mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .mem_read(rd0), .mem_write(wr0),
    .mem_addr(rq_addr), .mem_wdata(rq_wdata), .mem_rdata(rdata0),
    .mem_ready(ready0), .mem_busy(busy0), .mem_err(err0)
`ifdef MEM_STATS_EN
    , .rd_count(rdc0), .wr_count(wrc0)
`endif
  );

  always #5 CLK = ~CLK;

  // Issues one request and holds it until mem_ready, then drops it.
  // lat counts rising edges from the sampling edge up to the one raising
  // mem_ready (-1 on timeout). ready_next/busy_next are sampled one cycle later.
  task automatic do_access(input logic r, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input bit perturb,
                           output int lat, output logic [15:0] rd_v,
                           output logic err_v, output logic ready_next,
                           output logic busy_next, output logic busy_first);
    @(negedge CLK);
    rq_rd = r; rq_wr = w; rq_addr = a; rq_wdata = d;
    lat = 0; rd_v = 16'hxxxx; err_v = 1'bx; busy_first = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 1) begin
        busy_first = busy;
        if (perturb) begin
          rq_addr = a + 16'd1;
          rq_wdata = ~d;
        end
      end
      if (ready) begin
        rd_v = rdata;
        err_v = err;
        break;
      end
    end
    if (!ready) lat = -1;
    rq_rd = 1'b0; rq_wr = 1'b0;
    @(posedge CLK); #1;
    ready_next = ready;
    busy_next = busy;
  endtask

  int lat;
  logic [15:0] rv;
  logic ev, rn, bn, bf;

  task automatic test_reset();
    Reset = 1'b0; sel = 1'b0;
    rq_rd = 1'b0; rq_wr = 1'b0; rq_addr = '0; rq_wdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({rdata1, ready1, busy1, err1, rdata0, ready0, busy0, err0} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h/%b%b%b %h/%b%b%b want all zero",
               rdata1, ready1, busy1, err1, rdata0, ready0, busy0, err0);
    end
    @(negedge CLK); Reset = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    sel = 1'b0;
    do_access(1'b0, 1'b1, 16'd5, 16'h5555, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b1, 1'b0, 16'd5, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (rv !== 16'h5555) begin n_bad++; $display("FAIL pre_read5: got %h want 5555", rv); end
    // Start the BEEF write, then reset while it sits in WAIT.
    @(negedge CLK);
    rq_wr = 1'b1; rq_addr = 16'd5; rq_wdata = 16'hBEEF;
    @(posedge CLK); #1;
    n_cmp++;
    if (busy1 !== 1'b1) begin n_bad++; $display("FAIL mid_wait_busy: got %b want 1", busy1); end
    Reset = 1'b0;
    #1;
    n_cmp++;
    if ({rdata1, ready1, busy1, err1} !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_async_outputs: got %h %b%b%b want 0000 000", rdata1, ready1, busy1, err1);
    end
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({rdata1, ready1, busy1, err1} !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_held_outputs: got %h %b%b%b want 0000 000", rdata1, ready1, busy1, err1);
    end
    rq_wr = 1'b0;
    @(negedge CLK); Reset = 1'b1;
    do_access(1'b1, 1'b0, 16'd5, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (rv !== 16'h5555 || ev !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_read5: got %h err %b want 5555 err 0", rv, ev);
    end
  endtask

  task automatic test_wait1_latency();
    sel = 1'b0;
    do_access(1'b0, 1'b1, 16'd3, 16'h1234, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (lat !== 3 || rn !== 1'b0 || ev !== 1'b0) begin
      n_bad++; $display("FAIL w1_write_lat: got lat %0d next_ready %b err %b want 3 0 0", lat, rn, ev);
    end
    do_access(1'b1, 1'b0, 16'd3, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (lat !== 3 || rn !== 1'b0) begin
      n_bad++; $display("FAIL w1_read_lat: got lat %0d next_ready %b want 3 0", lat, rn);
    end
    n_cmp++;
    if (rv !== 16'h1234) begin n_bad++; $display("FAIL w1_read_data: got %h want 1234", rv); end
    n_cmp++;
    if (rdata1 !== 16'h1234) begin n_bad++; $display("FAIL rdata_hold: got %h want 1234", rdata1); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    do_access(1'b0, 1'b1, 16'd0, 16'h0001, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b0, 1'b1, 16'd1, 16'h0002, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b1, 1'b0, 16'd0, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (lat !== 2 || rv !== 16'h0001 || rn !== 1'b0) begin
      n_bad++; $display("FAIL w0_read0: got lat %0d data %h next_ready %b want 2 0001 0", lat, rv, rn);
    end
    n_cmp++;
    if (bn !== 1'b0) begin n_bad++; $display("FAIL w0_idle_gap: got busy %b want 0", bn); end
    do_access(1'b1, 1'b0, 16'd1, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (bf !== 1'b1) begin n_bad++; $display("FAIL w0_gap_one_cycle: got busy %b want 1", bf); end
    n_cmp++;
    if (lat !== 2 || rv !== 16'h0002) begin
      n_bad++; $display("FAIL w0_read1: got lat %0d data %h want 2 0002", lat, rv);
    end
    sel = 1'b0;
  endtask

  task automatic test_out_of_range();
    sel = 1'b0;
    do_access(1'b0, 1'b1, 16'd0, 16'h0A0A, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b1, 1'b0, 16'd0, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b1, 1'b0, 16'd1024, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (lat !== 3 || ev !== 1'b1 || rv !== 16'h0000) begin
      n_bad++; $display("FAIL oob_read: got lat %0d err %b data %h want 3 1 0000", lat, ev, rv);
    end
    do_access(1'b0, 1'b1, 16'd1024, 16'hFFFF, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (ev !== 1'b1) begin n_bad++; $display("FAIL oob_write_err: got %b want 1", ev); end
    do_access(1'b1, 1'b0, 16'd0, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (rv !== 16'h0A0A || ev !== 1'b0) begin
      n_bad++; $display("FAIL no_alias: got %h err %b want 0a0a err 0", rv, ev);
    end
  endtask

  task automatic test_both_and_addr_change();
    sel = 1'b0;
    do_access(1'b0, 1'b1, 16'd7, 16'h7777, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b1, 1'b0, 16'd7, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b1, 1'b1, 16'd7, 16'hDEAD, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (ev !== 1'b1 || rv !== 16'h0000) begin
      n_bad++; $display("FAIL both_err: got err %b data %h want 1 0000", ev, rv);
    end
    do_access(1'b1, 1'b0, 16'd7, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (rv !== 16'h7777) begin n_bad++; $display("FAIL both_no_write: got %h want 7777", rv); end
    do_access(1'b0, 1'b1, 16'd10, 16'h1010, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b0, 1'b1, 16'd9, 16'hA5A5, 1, lat, rv, ev, rn, bn, bf);
    do_access(1'b1, 1'b0, 16'd9, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (rv !== 16'hA5A5) begin n_bad++; $display("FAIL addr_change_target: got %h want a5a5", rv); end
    do_access(1'b1, 1'b0, 16'd10, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (rv !== 16'h1010) begin n_bad++; $display("FAIL addr_change_other: got %h want 1010", rv); end
  endtask

`ifdef MEM_STATS_EN
  task automatic test_stats();
    sel = 1'b0;
    @(negedge CLK); Reset = 1'b0;
    @(negedge CLK); Reset = 1'b1;
    n_cmp++;
    if (rdc1 !== 16'd0 || wrc1 !== 16'd0) begin
      n_bad++; $display("FAIL stats_reset: got %0d/%0d want 0/0", rdc1, wrc1);
    end
    do_access(1'b0, 1'b1, 16'd20, 16'h2020, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b0, 1'b1, 16'd21, 16'h2121, 0, lat, rv, ev, rn, bn, bf);
    for (int i = 0; i < 3; i++) do_access(1'b1, 1'b0, 16'd20, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    do_access(1'b1, 1'b0, 16'd2000, 16'h0, 0, lat, rv, ev, rn, bn, bf);
    n_cmp++;
    if (rdc1 !== 16'd3 || wrc1 !== 16'd2) begin
      n_bad++; $display("FAIL stats_counts: got %0d/%0d want 3/2", rdc1, wrc1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_write();
    test_wait1_latency();
    test_back_to_back();
    test_out_of_range();
    test_both_and_addr_change();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
